// File: rtl/sr_ff_monitor_if.sv
// Observation bus between an SR flip-flop under test and its monitor.
// The stimulus side drives S/R and the flop drives Q/Q_bar; the monitor only listens.
interface sr_ff_monitor_if;
  logic S;
  logic R;
  logic Q;
  logic Q_bar;

  modport master (output S, output R, output Q, output Q_bar);
  modport slave  (input  S, input  R, input  Q, input  Q_bar);
endinterface

// File: rtl/sr_ff_monitor.sv
// Golden-model checker and excitation decoder for an SR flip-flop observed on sr_ff_monitor_if.
// Latency: class/counters/state at the sampling edge, Q check and excitation one edge later; never stalls.
module sr_ff_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  sr_ff_monitor_if.slave   sr,
  output logic [1:0]       cls,
  output logic             known,
  output logic             err_mismatch,
  output logic             err_compl,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cnt_hold,
  output logic [CNT_W-1:0] cnt_reset,
  output logic [CNT_W-1:0] cnt_set,
  output logic [CNT_W-1:0] cnt_forb,
  output logic             exc_valid,
  output logic             exc_d,
  output logic             exc_t,
  output logic             exc_j,
  output logic             exc_k,
  output logic             exc_s,
  output logic             exc_r
);

  typedef enum logic [1:0] {
    CLS_HOLD  = 2'b00,
    CLS_RESET = 2'b01,
    CLS_SET   = 2'b10,
    CLS_FORB  = 2'b11
  } cls_t;

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_KNOWN   = 2'd1,
    ST_FORBID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  cls_t   cur_cls;
  state_t state;
  state_t state_nxt;
  logic   is_hold;
  logic   is_reset;
  logic   is_set;
  logic   is_forb;
  logic   state_known;

  // Pending check armed at edge k and resolved at edge k+1
  logic   exp_d;
  logic   chk_en;
  logic   chk_en_nxt;
  logic   exp_d_nxt;

  // Previous sampled Q, and whether it was sampled after reset
  logic   q_d;
  logic   q_vld;

  assign cur_cls     = cls_t'({sr.S, sr.R});
  assign is_hold     = (cur_cls == CLS_HOLD);
  assign is_reset    = (cur_cls == CLS_RESET);
  assign is_set      = (cur_cls == CLS_SET);
  assign is_forb     = (cur_cls == CLS_FORB);
  assign state_known = (state == ST_KNOWN);
  assign known       = state_known;

  // ---------------------------------------------------------------------------
  // Golden-model state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_UNKNOWN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNKNOWN: begin
        if (is_set || is_reset) begin
          state_nxt = ST_KNOWN;
        end else if (is_forb) begin
          state_nxt = ST_FORBID;
        end
      end
      ST_KNOWN: begin
        if (is_forb) begin
          state_nxt = ST_FORBID;
        end
      end
      ST_FORBID: begin
        if (is_set || is_reset) begin
          state_nxt = ST_KNOWN;
        end
      end
      default: begin
        state_nxt = ST_UNKNOWN;
      end
    endcase
  end

  // Hold only arms a check when the prior state is trustworthy; forbidden never does.
  always_comb begin
    chk_en_nxt = 1'b0;
    exp_d_nxt  = sr.Q;
    if (is_set) begin
      chk_en_nxt = 1'b1;
      exp_d_nxt  = 1'b1;
    end else if (is_reset) begin
      chk_en_nxt = 1'b1;
      exp_d_nxt  = 1'b0;
    end else if (is_hold) begin
      chk_en_nxt = state_known;
      exp_d_nxt  = sr.Q;
    end
  end

  // ---------------------------------------------------------------------------
  // Classification and saturating counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cls       <= 2'b00;
      cnt_hold  <= '0;
      cnt_reset <= '0;
      cnt_set   <= '0;
      cnt_forb  <= '0;
    end else begin
      cls <= cur_cls;
      if (is_hold && (cnt_hold != CNT_MAX)) begin
        cnt_hold <= cnt_hold + 1'b1;
      end
      if (is_reset && (cnt_reset != CNT_MAX)) begin
        cnt_reset <= cnt_reset + 1'b1;
      end
      if (is_set && (cnt_set != CNT_MAX)) begin
        cnt_set <= cnt_set + 1'b1;
      end
      if (is_forb && (cnt_forb != CNT_MAX)) begin
        cnt_forb <= cnt_forb + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response checking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_d        <= 1'b0;
      chk_en       <= 1'b0;
      err_mismatch <= 1'b0;
      err_compl    <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      exp_d        <= exp_d_nxt;
      chk_en       <= chk_en_nxt;
      err_mismatch <= chk_en & (sr.Q != exp_d);
      err_compl    <= state_known & (sr.Q == sr.Q_bar);
      err_sticky   <= err_sticky | err_mismatch | err_compl;
    end
  end

  // ---------------------------------------------------------------------------
  // Excitation decode of the q_d -> Q transition
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      q_d       <= 1'b0;
      q_vld     <= 1'b0;
      exc_valid <= 1'b0;
      exc_d     <= 1'b0;
      exc_t     <= 1'b0;
      exc_j     <= 1'b0;
      exc_k     <= 1'b0;
      exc_s     <= 1'b0;
      exc_r     <= 1'b0;
    end else begin
      q_d       <= sr.Q;
      q_vld     <= 1'b1;
      exc_valid <= q_vld;
      if (q_vld) begin
        // JK/SR don't-cares are resolved to 0
        exc_d <= sr.Q;
        exc_t <= q_d ^ sr.Q;
        exc_j <= ~q_d & sr.Q;
        exc_k <= q_d & ~sr.Q;
        exc_s <= ~q_d & sr.Q;
        exc_r <= q_d & ~sr.Q;
      end
    end
  end

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Bench: a behavioural SR flop with fault injection feeds two monitors (CNT_W 8 and 2);
// an event-history reference model predicts every output, a negedge monitor compares.
module tb_sr_ff_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_ff_monitor_if sr_bus ();

  logic [1:0] cls_a, cls_b;
  logic known_a, mism_a, compl_a, sticky_a, ev_a, d_a, t_a, j_a, k_a, s_a, r_a;
  logic known_b, mism_b, compl_b, sticky_b, ev_b, d_b, t_b, j_b, k_b, s_b, r_b;
  logic [7:0] ch_a, cr_a, cs_a, cf_a;
  logic [1:0] ch_b, cr_b, cs_b, cf_b;

  sr_ff_monitor #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .sr(sr_bus),
    .cls(cls_a), .known(known_a), .err_mismatch(mism_a), .err_compl(compl_a), .err_sticky(sticky_a),
    .cnt_hold(ch_a), .cnt_reset(cr_a), .cnt_set(cs_a), .cnt_forb(cf_a),
    .exc_valid(ev_a), .exc_d(d_a), .exc_t(t_a), .exc_j(j_a), .exc_k(k_a), .exc_s(s_a), .exc_r(r_a)
  );

  sr_ff_monitor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .sr(sr_bus),
    .cls(cls_b), .known(known_b), .err_mismatch(mism_b), .err_compl(compl_b), .err_sticky(sticky_b),
    .cnt_hold(ch_b), .cnt_reset(cr_b), .cnt_set(cs_b), .cnt_forb(cf_b),
    .exc_valid(ev_b), .exc_d(d_b), .exc_t(t_b), .exc_j(j_b), .exc_k(k_b), .exc_s(s_b), .exc_r(r_b)
  );

  typedef struct {
    logic [1:0] cls;
    logic known, mism, compl, sticky;
    int   ch, cr, cs, cf;
    logic ev, d, t, j, k, s, r;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  // Reference-model history
  int   t_idx = 0;
  int   last_sr = -1;
  int   last_forb = -1;
  int   edges = 0;
  bit   arm_vld = 0;
  bit   arm_val = 0;
  bit   sticky_acc = 0;
  bit   prev_q = 0;
  int   n_h = 0, n_r = 0, n_s = 0, n_f = 0;
  bit   ff_q = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
  endtask

  // Expected outputs after the coming edge, derived from event history.
  task automatic model_edge(input bit rv, input bit sv, input bit rr, input bit q, input bit qb);
    exp_t e;
    bit kb;
    e = '{default: 0};
    if (rv) begin
      last_sr = -1; last_forb = -1; edges = 0;
      arm_vld = 0; arm_val = 0; sticky_acc = 0;
      n_h = 0; n_r = 0; n_s = 0; n_f = 0;
    end else begin
      kb = (last_sr >= 0) && (last_sr > last_forb);
      e.mism   = arm_vld && (q != arm_val);
      e.compl  = kb && (q == qb);
      e.sticky = sticky_acc;
      sticky_acc = sticky_acc | e.mism | e.compl;
      e.cls = {sv, rr};
      if (sv && rr) begin
        n_f++; arm_vld = 0; last_forb = t_idx;
      end else if (sv || rr) begin
        if (sv) n_s++; else n_r++;
        arm_vld = 1; arm_val = sv; last_sr = t_idx;
      end else begin
        n_h++; arm_vld = kb; arm_val = q;
      end
      e.known = (last_sr >= 0) && (last_sr > last_forb);
      e.ch = n_h; e.cr = n_r; e.cs = n_s; e.cf = n_f;
      if (edges >= 1) begin
        e.ev = 1; e.d = q; e.t = (prev_q != q);
        e.j = (!prev_q && q); e.s = e.j;
        e.k = (prev_q && !q); e.r = e.k;
      end
      prev_q = q;
      edges++;
    end
    t_idx++;
    sb.push_back(e);
  endtask

  // One clock: apply stimulus and the flop's (optionally faulted) response.
  task automatic step(input bit rv, input bit sv, input bit rr, input bit fq, input bit fc);
    bit qv;
    qv = ff_q ^ fq;
    rst = rv;
    sr_bus.S = sv;
    sr_bus.R = rr;
    sr_bus.Q = qv;
    sr_bus.Q_bar = fc ? qv : ~qv;
    model_edge(rv, sv, rr, qv, fc ? qv : ~qv);
    @(posedge clk);
    #1;
    if (rv) ff_q = 0;
    else if (sv && !rr) ff_q = 1;
    else if (!sv && rr) ff_q = 0;
    else if (sv && rr) ff_q = 1'($urandom_range(0, 1));
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("cls", int'(cls_a), int'(e.cls));
      chk("known", int'(known_a), int'(e.known));
      chk("err_mismatch", int'(mism_a), int'(e.mism));
      chk("err_compl", int'(compl_a), int'(e.compl));
      chk("err_sticky", int'(sticky_a), int'(e.sticky));
      chk("cnt_hold", int'(ch_a), sat(e.ch, 255));
      chk("cnt_reset", int'(cr_a), sat(e.cr, 255));
      chk("cnt_set", int'(cs_a), sat(e.cs, 255));
      chk("cnt_forb", int'(cf_a), sat(e.cf, 255));
      chk("exc_valid", int'(ev_a), int'(e.ev));
      chk("exc_dt", int'({d_a, t_a}), int'({e.d, e.t}));
      chk("exc_jksr", int'({j_a, k_a, s_a, r_a}), int'({e.j, e.k, e.s, e.r}));
      chk("w2_cnt_hold", int'(ch_b), sat(e.ch, 3));
      chk("w2_cnt_reset", int'(cr_b), sat(e.cr, 3));
      chk("w2_cnt_set", int'(cs_b), sat(e.cs, 3));
      chk("w2_cnt_forb", int'(cf_b), sat(e.cf, 3));
      chk("w2_flags", int'({known_b, mism_b, compl_b, sticky_b, ev_b}),
          int'({e.known, e.mism, e.compl, e.sticky, e.ev}));
    end
  end

  initial begin
    sr_bus.S = 0; sr_bus.R = 0; sr_bus.Q = 0; sr_bus.Q_bar = 1;
    // Reset then idle holds
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    // hold, reset, hold, set, hold, forbidden, hold
    step(0, 0, 0, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 1, 1, 0, 0); step(0, 0, 0, 0, 0);
    // Mismatch: Q forced low the cycle after a set
    step(0, 1, 0, 0, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    // Complement fault while known, then after forbidden
    step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
    // Saturation of the narrow counters
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Reset right after a set with a faulted Q
    step(0, 1, 0, 0, 0); step(1, 0, 0, 1, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    // Wide counter saturation
    step(0, 0, 1, 0, 0);
    repeat (300) step(0, 0, 0, 0, 0);
    // Randomized traffic with faults and occasional resets
    for (int i = 0; i < 600; i++) begin
      int sel;
      bit sv, rr;
      sel = $urandom_range(0, 9);
      sv = (sel >= 4 && sel <= 6) || (sel == 9);
      rr = (sel >= 7);
      step(($urandom_range(0, 59) == 0), sv, rr,
           ($urandom_range(0, 14) == 0), ($urandom_range(0, 19) == 0));
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
